bcd_sseg_mux: RTL
=================

Name: bcd_sseg_mux

Overview:
- Downstream consumer of the BCD counter chain.
- Captures N_DIGITS packed BCD digits on a load strobe, typically the counter's done pulse or a per-period strobe.
- Time-multiplexes the captured digits onto one common-anode seven-segment display: one digit lit at a time, advancing at a fixed refresh rate.
- Sits between the counter datapath and the board display pins; all display outputs are registered.

Parameters:
- N_DIGITS, 4, number of digits multiplexed (legal range 2..8).
- REFRESH_DIV, 50000, clock cycles each digit stays lit (legal range 2 or more); at 50 MHz this gives 1 ms per digit.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- load  input  1  when high at a rising edge, bcd_in and dp_in are captured into the snapshot.
- bcd_in  input  4*N_DIGITS  packed BCD; digit i occupies bits [4i+3:4i]; digit 0 is least significant and rightmost.
- dp_in  input  N_DIGITS  decimal point request per digit, active high.
- an  output  N_DIGITS  anode enables, active low, one-hot-low while running.
- sseg  output  7  segments {g,f,e,d,c,b,a}, active low.
- dp  output  1  decimal point segment, active low.
- digit_idx  output  clog2(N_DIGITS)  index of the digit currently shown on an/sseg.

Behaviour:
- Reset is asynchronous while reset_n = 0:
  - snapshot, dp snapshot, refresh counter and internal index all clear to 0;
  - an = all ones (display dark), sseg = 7'h7F, dp = 1, digit_idx = 0.
- Snapshot:
  - load = 1 at edge k copies bcd_in and dp_in into the snapshot.
  - load = 0 holds the snapshot, so the display does not tear while the counter is running.
- Refresh counter:
  - counts 0..REFRESH_DIV-1 and wraps to 0;
  - tick = counter at REFRESH_DIV-1;
  - on tick, the internal index increments and wraps from N_DIGITS-1 to 0.
- Output stage is one register stage:
  - an, sseg, dp and digit_idx at edge k+1 reflect the internal index and snapshot as they stood after edge k.
  - The first lit digit (index 0) appears at the first edge after reset_n rises.
- Each digit stays lit for exactly REFRESH_DIV cycles; a full scan takes N_DIGITS*REFRESH_DIV cycles.
- an = ~(1 << digit_idx).
- Decode table for sseg:
  - 0 -> 1000000
  - 1 -> 1111001
  - 2 -> 0100100
  - 3 -> 0110000
  - 4 -> 0011001
  - 5 -> 0010010
  - 6 -> 0000010
  - 7 -> 1111000
  - 8 -> 0000000
  - 9 -> 0010000
  - codes 10..15 -> 0111111 (dash, segment g only).
- dp = ~dp_snapshot[digit_idx].
- load and tick in the same cycle: both take effect at that edge, and the output at the next edge shows the new digit from the new snapshot.
- load held high continuously: the snapshot follows bcd_in every cycle, with a two-edge path from input to pins.
- Reset asserted mid-scan: all outputs go dark immediately, without waiting for a clock. The scan restarts at digit 0 with an empty (zero) snapshot.

Optional Feature:
- Macro: LEADING_ZERO_BLANK_EN.
- Defined:
  - a digit whose snapshot value is 0 and whose more-significant digits are all 0 is blanked: sseg = 1111111, dp follows dp_in normally;
  - digit 0 is never blanked, so a value of 0 shows "0";
  - the anode still cycles normally, so brightness is unchanged.
- Not defined: every digit is decoded per the table, and zeros are shown as "0".

Test Plan (N_DIGITS = 4, REFRESH_DIV = 4):
- Reset then release, with no load:
  - during reset: an = 1111, sseg = 1111111, dp = 1;
  - after reset: an walks 1110, 1101, 1011, 0111, each for 4 cycles, then repeats;
  - sseg = 1000000 on every digit.
- load = 1 for one cycle with bcd_in = 16'h1234 and dp_in = 4'b0100:
  - digit 0 shows 0011001, digit 1 shows 0110000, digit 2 shows 0100100, digit 3 shows 1111001;
  - dp = 0 only while an = 1011.
- bcd_in = 16'h0A0F loaded:
  - digits 0 and 2 show 0111111 (dash);
  - digits 1 and 3 show 1000000.
- load asserted in the same cycle as tick with a changed value:
  - the next lit digit shows the new value;
  - no stale value appears for even one cycle.
- Assert reset_n = 0 midway through the digit-2 slot:
  - an = 1111 immediately, without a clock edge;
  - after release, the scan restarts at digit 0 showing 1000000.
- With LEADING_ZERO_BLANK_EN defined, load 16'h0050:
  - digits 3 and 2 show 1111111;
  - digit 1 shows 0010010;
  - digit 0 shows 1000000.
  - Then load 16'h0000: only digit 0 is lit, showing 1000000.

Source files
------------

// File: rtl/bcd_sseg_mux.sv
// ---------------------------------------------------------------------------
// bcd_sseg_mux
//
// Captures N_DIGITS packed BCD digits on a load strobe and time-multiplexes
// them onto one common-anode seven-segment display, one digit at a time.
// Each digit stays lit for REFRESH_DIV clock cycles. All display outputs are
// registered, one stage after the scan index and snapshot.
//
// Optional build macro: LEADING_ZERO_BLANK_EN
//   defined   - zero digits with only zeros above them are blanked
//               (digit 0 is never blanked); anodes keep cycling normally
//   undefined - every digit is decoded, zeros are shown as "0"
//
// Ports:
//   clk        in   system clock, rising edge
//   reset_n    in   asynchronous active-low reset
//   load       in   capture bcd_in / dp_in into the snapshot
//   bcd_in     in   [4*N_DIGITS] packed BCD, digit 0 in bits [3:0] (rightmost)
//   dp_in      in   [N_DIGITS] decimal point request per digit, active high
//   an         out  [N_DIGITS] anode enables, active low, one-hot-low
//   sseg       out  [7] segments {g,f,e,d,c,b,a}, active low
//   dp         out  decimal point segment, active low
//   digit_idx  out  [clog2(N_DIGITS)] index of the digit being shown
// ---------------------------------------------------------------------------
module bcd_sseg_mux #(
    parameter int N_DIGITS    = 4,
    parameter int REFRESH_DIV = 50000
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        load,
    input  logic [4*N_DIGITS-1:0]       bcd_in,
    input  logic [N_DIGITS-1:0]         dp_in,
    output logic [N_DIGITS-1:0]         an,
    output logic [6:0]                  sseg,
    output logic                        dp,
    output logic [$clog2(N_DIGITS)-1:0] digit_idx
);

    localparam int IDX_W = $clog2(N_DIGITS);
    localparam int CNT_W = $clog2(REFRESH_DIV);

    logic [4*N_DIGITS-1:0] r_snap;
    logic [N_DIGITS-1:0]   r_dp_snap;
    logic [CNT_W-1:0]      r_cnt;
    logic [IDX_W-1:0]      r_idx;

    logic [N_DIGITS-1:0]   r_an;
    logic [6:0]            r_sseg;
    logic                  r_dp;
    logic [IDX_W-1:0]      r_digit_idx;

    logic                  w_tick;
    logic [3:0]            w_digit;
    logic [6:0]            w_seg_dec;
    logic [6:0]            w_seg;
    logic [N_DIGITS-1:0]   w_an;

    assign w_tick  = (r_cnt == CNT_W'(REFRESH_DIV - 1));
    assign w_digit = 4'(r_snap >> {r_idx, 2'b00});
    assign w_an    = ~({{(N_DIGITS-1){1'b0}}, 1'b1} << r_idx);

    always_comb begin
        w_seg_dec = 7'b0111111;
        case (w_digit)
            4'd0:    w_seg_dec = 7'b1000000;
            4'd1:    w_seg_dec = 7'b1111001;
            4'd2:    w_seg_dec = 7'b0100100;
            4'd3:    w_seg_dec = 7'b0110000;
            4'd4:    w_seg_dec = 7'b0011001;
            4'd5:    w_seg_dec = 7'b0010010;
            4'd6:    w_seg_dec = 7'b0000010;
            4'd7:    w_seg_dec = 7'b1111000;
            4'd8:    w_seg_dec = 7'b0000000;
            4'd9:    w_seg_dec = 7'b0010000;
            default: w_seg_dec = 7'b0111111;
        endcase
    end

`ifdef LEADING_ZERO_BLANK_EN
    // Shifting the snapshot down by the current index leaves this digit and
    // everything more significant; all-zero means it is a leading zero.
    logic w_blank;
    assign w_blank = (r_idx != '0) && ((r_snap >> {r_idx, 2'b00}) == '0);
    assign w_seg   = w_blank ? 7'b1111111 : w_seg_dec;
`else
    assign w_seg   = w_seg_dec;
`endif

    // Snapshot, refresh counter and scan index
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_snap    <= '0;
            r_dp_snap <= '0;
            r_cnt     <= '0;
            r_idx     <= '0;
        end else begin
            if (load) begin
                r_snap    <= bcd_in;
                r_dp_snap <= dp_in;
            end
            if (w_tick) begin
                r_cnt <= '0;
                if (r_idx == IDX_W'(N_DIGITS - 1))
                    r_idx <= '0;
                else
                    r_idx <= r_idx + IDX_W'(1);
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    // Output register stage: reflects index and snapshot after the previous edge
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_an        <= '1;
            r_sseg      <= 7'h7F;
            r_dp        <= 1'b1;
            r_digit_idx <= '0;
        end else begin
            r_an        <= w_an;
            r_sseg      <= w_seg;
            r_dp        <= ~r_dp_snap[r_idx];
            r_digit_idx <= r_idx;
        end
    end

    assign an        = r_an;
    assign sseg      = r_sseg;
    assign dp        = r_dp;
    assign digit_idx = r_digit_idx;

endmodule
